// File: rtl/aes_stream_pkg.sv
// Shared constants and index arithmetic for the byte-serial AES ShiftRows datapath.
// State bytes are numbered column-major: index = row + 4*col.
package aes_stream_pkg;

  localparam int NB_DEFAULT = 4;
  localparam int L_DEFAULT  = 4 * NB_DEFAULT;

  function automatic int blk_len(input int nb);
    return 4 * nb;
  endfunction

  // Rijndael row rotation amounts; only the 256-bit block stretches rows 2 and 3.
  function automatic int row_offset(input int nb, input int row);
    int off;
    case (row)
      1:       off = 1;
      2:       off = (nb == 8) ? 3 : 2;
      3:       off = (nb == 8) ? 4 : 3;
      default: off = 0;
    endcase
    return off;
  endfunction

  // Input index that lands at output index k; inv selects InvShiftRows.
  function automatic int map_idx(input int nb, input int k, input logic inv);
    int row;
    int col;
    int src_col;
    row = k % 4;
    col = k / 4;
    if (!inv) begin
      src_col = col + row_offset(nb, row);
      if (src_col >= nb) src_col = src_col - nb;
    end else begin
      src_col = col - row_offset(nb, row);
      if (src_col < 0) src_col = src_col + nb;
    end
    return row + 4 * src_col;
  endfunction

endpackage

// File: rtl/shift_rows_bank.sv
// One block-sized register bank with its full flag and latched direction bit.
// The read port applies the ShiftRows/InvShiftRows permutation on the fly.
module shift_rows_bank
  import aes_stream_pkg::*;
#(
  parameter int W  = 8,
  parameter int NB = NB_DEFAULT,
  localparam int L  = blk_len(NB),
  localparam int IW = $clog2(L)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          wr_inv_i,
  input  logic          set_full_i,
  input  logic          clr_full_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic          full_o,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0]  mem_q [L];
  logic          full_q;
  logic          inv_q;
  logic [IW-1:0] src_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < L; i++) mem_q[i] <= '0;
      full_q <= 1'b0;
      inv_q  <= 1'b0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_idx_i] <= wr_data_i;
        // Direction is a per-block property, captured with the first byte.
        if (wr_idx_i == '0) inv_q <= wr_inv_i;
      end
      if (set_full_i)      full_q <= 1'b1;
      else if (clr_full_i) full_q <= 1'b0;
    end
  end

  always_comb begin
    src_idx = IW'(map_idx(NB, int'(rd_idx_i), inv_q));
  end

  assign rd_data_o = mem_q[src_idx];
  assign full_o    = full_q;

endmodule

// File: rtl/shift_rows_stream.sv
// Ping-pong byte-serial ShiftRows/InvShiftRows unit: one bank fills while the
// other drains, giving one symbol per cycle on both sides.
module shift_rows_stream
  import aes_stream_pkg::*;
#(
  parameter int W  = 8,
  parameter int NB = NB_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_inv,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready
);

  localparam int L  = blk_len(NB);
  localparam int IW = $clog2(L);
  localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);

  // Handshake: a symbol moves when valid && ready on the same rising edge.
  // ready/valid come only from registered full flags, so neither side
  // combinationally depends on the other.
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]    full;
  logic [W-1:0]  rd_data [2];
  logic          in_fire;
  logic          out_fire;

  assign in_ready  = !full[wr_bank_q];
  assign out_valid = full[rd_bank_q];
  assign out_data  = rd_data[rd_bank_q];
  assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    shift_rows_bank #(
      .W  (W),
      .NB (NB)
    ) u_bank (
      .clk_i      (clk),
      .rst_ni     (rst),
      .wr_en_i    (in_fire && (wr_bank_q == 1'(g))),
      .wr_idx_i   (wr_idx_q),
      .wr_data_i  (in_data),
      .wr_inv_i   (in_inv),
      .set_full_i (in_fire && (wr_bank_q == 1'(g)) && (wr_idx_q == LAST_IDX)),
      .clr_full_i (out_fire && (rd_bank_q == 1'(g)) && (rd_idx_q == LAST_IDX)),
      .rd_idx_i   (rd_idx_q),
      .full_o     (full[g]),
      .rd_data_o  (rd_data[g])
    );
  end

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    if (in_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IW'(1);
      end
    end
    if (out_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_idx_q  <= rd_idx_d;
      rd_bank_q <= rd_bank_d;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: port 0 drives an NB=4 instance, port 1 an NB=8
// instance; a queue-based block model predicts every output cycle.
module tb_shift_rows_stream;
  import aes_stream_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][7:0] in_data;
  logic [1:0]      in_valid;
  logic [1:0]      in_inv;
  logic [1:0]      out_ready;
  wire  [1:0]      in_ready;
  wire  [1:0][7:0] out_data;
  wire  [1:0]      out_valid;
  wire  [1:0]      out_last;

  shift_rows_stream #(.W(8), .NB(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_inv(in_inv[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]), .out_ready(out_ready[0])
  );

  shift_rows_stream #(.W(8), .NB(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_inv(in_inv[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]), .out_ready(out_ready[1])
  );

  localparam logic [7:0] FWD4 [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                       8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
  localparam logic [7:0] INV4 [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                       8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  localparam logic [7:0] FWD8_HEAD [4] = '{8'h00, 8'h05, 8'h0E, 8'h13};

  // ---------------- scoreboard / model state ----------------
  logic [7:0] exp_q   [2][$];
  logic [7:0] part_q  [2][$];
  logic [7:0] out_log [2][$];
  bit         part_inv [2];
  int         acc_cnt  [2];
  int         stall_cnt[2];
  int         outv_cnt [2];
  int         chk_cnt = 0;
  int         err_cnt = 0;

  function automatic void check(input string name, input int act, input int req);
    chk_cnt++;
    if (act != req) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Which input byte lands at output k: rotate each row's columns by its offset.
  function automatic int model_src(input int nb, input int k, input bit inv);
    int r;
    int c;
    int off;
    r   = k % 4;
    c   = k / 4;
    off = (r == 0) ? 0 : ((nb == 8 && r >= 2) ? r + 1 : r);
    return inv ? r + 4 * ((c - off + nb) % nb) : r + 4 * ((c + off) % nb);
  endfunction

  // Compare process: checks outputs each falling edge, then applies the
  // transfers that will occur on the next rising edge to the model.
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        int len;
        int sz;
        len = (p == 0) ? 16 : 32;
        if (!rst) begin
          check("rst_out_valid", int'(out_valid[p]), 0);
          check("rst_out_last",  int'(out_last[p]),  0);
          check("rst_out_data",  int'(out_data[p]),  0);
          check("rst_in_ready",  int'(in_ready[p]),  1);
          exp_q[p].delete();
          part_q[p].delete();
        end else begin
          sz = exp_q[p].size();
          check("in_ready",  int'(in_ready[p]),  (((sz + len - 1) / len) < 2) ? 1 : 0);
          check("out_valid", int'(out_valid[p]), (sz > 0) ? 1 : 0);
          if (sz > 0) begin
            check("out_data", int'(out_data[p]), int'(exp_q[p][0]));
            check("out_last", int'(out_last[p]), ((sz - 1) % len == 0) ? 1 : 0);
          end else begin
            check("out_last_idle", int'(out_last[p]), 0);
          end
          if (out_valid[p]) outv_cnt[p]++;
          if (in_valid[p] && !in_ready[p]) stall_cnt[p]++;
          if (out_valid[p] && out_ready[p] && sz > 0) begin
            out_log[p].push_back(out_data[p]);
            void'(exp_q[p].pop_front());
          end
          if (in_valid[p] && in_ready[p]) begin
            acc_cnt[p]++;
            if (part_q[p].size() == 0) part_inv[p] = in_inv[p];
            part_q[p].push_back(in_data[p]);
            if (part_q[p].size() == len) begin
              for (int k = 0; k < len; k++)
                exp_q[p].push_back(part_q[p][model_src(len / 4, k, part_inv[p])]);
              part_q[p].delete();
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_syms(input int p, input int n, input bit inv, input bit rnd,
                           input int base, input int gap);
    int t;
    for (int k = 0; k < n; k++) begin
      if (gap > 0) begin
        int g;
        g = $urandom_range(0, gap);
        if (g > 0) begin
          in_valid[p] = 1'b0;
          repeat (g) begin @(posedge clk); #1; end
        end
      end
      in_data[p]  = rnd ? 8'($urandom) : 8'(base + k);
      in_inv[p]   = (k == 0) ? inv : 1'($urandom);
      in_valid[p] = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready[p] && t < 400) begin
        @(negedge clk);
        t++;
      end
      check("in_ready_wait", int'(in_ready[p]), 1);
      if (!in_ready[p]) begin
        in_valid[p] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid[p] = 1'b0;
  endtask

  task automatic wait_drain(input int p);
    int t;
    t = 0;
    while (exp_q[p].size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", exp_q[p].size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus + final report ----------------
  initial begin
    bit stop;
    in_valid  = '0;
    in_data   = '0;
    in_inv    = '0;
    out_ready = 2'b11;
    for (int p = 0; p < 2; p++) begin
      acc_cnt[p] = 0; stall_cnt[p] = 0; outv_cnt[p] = 0; part_inv[p] = 1'b0;
    end
    fork
      monitor();
      begin
        #3000000;
        check("watchdog_pending", exp_q[0].size() + exp_q[1].size(), -1);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
      end
    join_none

    // Pin the model with hand-derived literals and the shared package map.
    for (int k = 0; k < 16; k++) begin
      check("pin_fwd4", model_src(4, k, 1'b0), int'(FWD4[k]));
      check("pin_inv4", model_src(4, k, 1'b1), int'(INV4[k]));
    end
    for (int k = 0; k < 4; k++) check("pin_fwd8", model_src(8, k, 1'b0), int'(FWD8_HEAD[k]));
    check("pin_len", blk_len(NB_DEFAULT), 16);
    for (int nb = 4; nb <= 8; nb += 2)
      for (int inv = 0; inv < 2; inv++)
        for (int k = 0; k < 4 * nb; k++)
          check("pkg_map", map_idx(nb, k, 1'(inv)), model_src(nb, k, 1'(inv)));

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Forward NB=4 on counting bytes.
    send_syms(0, 16, 1'b0, 1'b0, 0, 0);
    wait_drain(0);
    check("t1_count", out_log[0].size(), 16);
    for (int k = 0; k < 16; k++)
      if (k < out_log[0].size()) check("t1_fwd_seq", int'(out_log[0][k]), int'(FWD4[k]));
    out_log[0].delete();

    // Inverse NB=4 on counting bytes.
    send_syms(0, 16, 1'b1, 1'b0, 0, 0);
    wait_drain(0);
    check("t2_count", out_log[0].size(), 16);
    for (int k = 0; k < 16; k++)
      if (k < out_log[0].size()) check("t2_inv_seq", int'(out_log[0][k]), int'(INV4[k]));
    out_log[0].delete();

    // Back-to-back forward then inverse, no gaps.
    stall_cnt[0] = 0;
    outv_cnt[0]  = 0;
    send_syms(0, 16, 1'b0, 1'b1, 0, 0);
    send_syms(0, 16, 1'b1, 1'b1, 0, 0);
    wait_drain(0);
    check("t3_no_stall", stall_cnt[0], 0);
    check("t3_contiguous", outv_cnt[0], 32);
    check("t3_count", out_log[0].size(), 32);
    out_log[0].delete();

    // Backpressure: 40 symbols with the sink stalled.
    out_ready[0] = 1'b0;
    acc_cnt[0]   = 0;
    fork
      send_syms(0, 40, 1'($urandom), 1'b1, 0, 0);
      begin
        repeat (60) begin @(posedge clk); #1; end
        check("t4_accepts_stalled", acc_cnt[0], 32);
        check("t4_in_ready_low", int'(in_ready[0]), 0);
        out_ready[0] = 1'b1;
      end
    join
    check("t4_accepts_all", acc_cnt[0], 40);
    wait_drain(0);
    check("t4_drained", out_log[0].size(), 32);
    send_syms(0, 8, 1'b0, 1'b1, 0, 0);
    wait_drain(0);
    check("t4_total", out_log[0].size(), 48);
    out_log[0].delete();

    // Reset in the middle of a block.
    send_syms(0, 7, 1'b0, 1'b1, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", int'(out_valid[0]), 0);
    check("t5_rst_ready", int'(in_ready[0]), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    out_log[0].delete();
    send_syms(0, 16, 1'b0, 1'b0, 0, 0);
    wait_drain(0);
    check("t5_count", out_log[0].size(), 16);
    for (int k = 0; k < 16; k++)
      if (k < out_log[0].size()) check("t5_fwd_seq", int'(out_log[0][k]), int'(FWD4[k]));
    out_log[0].delete();

    // Random stress with gaps and a jittery sink.
    stop = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++) send_syms(0, 16, 1'($urandom), 1'b1, 0, 2);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          out_ready[0] = ($urandom_range(0, 3) != 0);
        end
        out_ready[0] = 1'b1;
      end
    join
    wait_drain(0);
    check("t6_count", out_log[0].size(), 128);
    out_log[0].delete();

    // NB=8 forward on counting bytes, then a random inverse block.
    send_syms(1, 32, 1'b0, 1'b0, 0, 0);
    wait_drain(1);
    check("t7_count", out_log[1].size(), 32);
    for (int k = 0; k < 4; k++)
      if (k < out_log[1].size()) check("t7_fwd8_head", int'(out_log[1][k]), int'(FWD8_HEAD[k]));
    send_syms(1, 32, 1'b1, 1'b1, 0, 1);
    wait_drain(1);
    check("t7_total", out_log[1].size(), 64);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
- Parametrised byte-serial ShiftRows / InvShiftRows permutation unit for the low-area AES datapath.
- Accepts one W-bit state byte per cycle in AES column-major order (index i = row + 4*col) and emits the permuted block in the same order.
- Two ping-pong banks allow continuous one-byte-per-cycle streaming with valid/ready handshakes on both sides.
- Supports forward/inverse mode per block and Rijndael block widths NB = 4, 6 or 8 columns.

Parameters:
- W, 8, symbol width in bits.
- NB, 4, state columns; legal values 4, 6, 8. Block length L = 4*NB symbols.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  W  input symbol.
- in_valid  in  1  input symbol valid.
- in_inv  in  1  mode, sampled with the first symbol of each block; 0 = ShiftRows, 1 = InvShiftRows.
- in_ready  out  1  unit can accept a symbol this cycle.
- out_data  out  W  permuted output symbol.
- out_valid  out  1  out_data valid.
- out_last  out  1  high with the final symbol (index L-1) of a block.
- out_ready  in  1  downstream accepts the symbol this cycle.

Behaviour:
- Row offsets: C0 = 0, C1 = 1, C2 = 2 (3 if NB = 8), C3 = 3 (4 if NB = 8).
- Forward mapping: output index k = r + 4c takes input index r + 4*((c + Cr) mod NB).
- Inverse mapping: output index k takes input index r + 4*((c - Cr + NB) mod NB).
- Storage: two banks of L x W registers. Per bank: full flag and latched inv bit.
- Pointers: wr_bank, wr_idx (0..L-1), rd_bank, rd_idx (0..L-1).
- Input accept: transfer when in_valid && in_ready; in_ready = !full[wr_bank] (registered flags only, no same-cycle pass-through).
- On accept, bank[wr_bank][wr_idx] <= in_data. If wr_idx == 0, also latch inv[wr_bank] <= in_inv.
- When wr_idx == L-1 on accept: wr_idx wraps to 0, full[wr_bank] set, wr_bank toggles.
- Output path: out_valid = full[rd_bank]. out_data = bank[rd_bank][map(rd_idx, inv[rd_bank])], combinational mux from registers. out_last = out_valid && rd_idx == L-1.
- Output transfer when out_valid && out_ready. When rd_idx == L-1 on transfer: clear full[rd_bank], rd_idx wraps to 0, rd_bank toggles.
- Latency: first output symbol is valid in the cycle after the L-th input symbol is accepted.
- Throughput: with out_ready held at 1, input and output each sustain one symbol per cycle indefinitely.
- Simultaneous final write to one bank and final read of the other: both take effect; the flags are independent.
- A bank freed on cycle t is not writable until cycle t+1.
- Both banks full: in_ready = 0 until the read bank drains completely.
- out_data stays stable while out_valid && !out_ready.
- in_valid deasserted mid-block: wr_idx holds and the partial block is retained.
- Reset (rst = 0, any time, including mid-block or mid-drain): all pointers 0, full flags 0, inv bits 0, bank contents 0. Partial blocks are discarded. Outputs go to out_valid = 0, out_last = 0, out_data = 0, in_ready = 1.
- Nothing is emitted for a block that is never completed.

Decomposition:
- Shared package aes_stream_pkg holds:
  - the row-offset function/constants for NB 4/6/8;
  - the forward/inverse index-map function (used by RTL and bench model);
  - the L = 4*NB constant.
- One sub-module, shift_rows_bank: one L x W register bank plus its full flag and inv bit, with write port and indexed read mux.
- Top level instantiates two banks plus the pointer/handshake control.

Test Plan:
- Forward, NB = 4: inputs 00..0F, in_inv = 0, out_ready = 1. Output must be 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B; out_last only on 0B; first out_valid one cycle after byte 0F is accepted.
- Inverse, NB = 4: same input with in_inv = 1. Output must be 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03.
- Back-to-back, mixed mode: two blocks (forward, then inverse) with no gaps and out_ready = 1. in_ready stays 1 for all 32 inputs; outputs are contiguous for 32 cycles, and the second block uses the inverse map.
- Backpressure: out_ready = 0 while feeding 40 symbols. in_ready falls after the 32nd accept and symbols 33..40 stall. Releasing out_ready drains block 1 in order, then in_ready returns to 1. No loss or duplication.
- Reset mid-block: rst low after 7 symbols accepted. out_valid = 0 and in_ready = 1 immediately; a fresh block 00..0F then produces the exact forward sequence above.
- NB = 8 forward: inputs 00..1F. Output starts 00,05,0E,13 (row offsets 0,1,3,4) and matches the package map for all 32 symbols.
